ldl_rr_dispatch_v1: RTL and testbench
=====================================

Name: ldl_rr_dispatch_v1

Overview:
- Round-robin dispatcher: one input stream is distributed across REQ_WIDTH downstream consumers. It is the 1-to-N counterpart of the N-to-1 round-robin arbiter.
- Each consumer is credit-gated: one credit per beat dispatched, credits returned by the consumer via pulses.
- Output is a single registered beat tagged with a target index (bin) and a one-hot (hot), for a shared fanout fabric.

Parameters:
- BIN_WIDTH, 3, width of the target index.
- REQ_WIDTH, 1<<BIN_WIDTH, number of consumers.
- DATA_WIDTH, 32, payload width.
- CREDIT_WIDTH, 2, per-consumer credit counter width; maximum credit is 2^CREDIT_WIDTH-1.
- CREDIT_INIT, 3, credits per consumer after reset; must be <= 2^CREDIT_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_data  in  DATA_WIDTH  input payload.
- cred_ret  in  REQ_WIDTH  per-consumer credit return pulses, one credit per set bit per cycle.
- out_valid  out  1  output beat valid (registered).
- out_ready  in  1  fabric accepts the output beat.
- out_data  out  DATA_WIDTH  registered payload.
- out_bin  out  BIN_WIDTH  target consumer index; also serves as the round-robin pointer.
- out_hot  out  REQ_WIDTH  one-hot of out_bin when out_valid, else 0.
- credit_avail  out  REQ_WIDTH  bit i = credit counter i nonzero.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0.
  - out_bin=REQ_WIDTH-1, so the first dispatch goes to consumer 0.
  - out_hot=0.
  - All credit counters = CREDIT_INIT.
  - in_ready=0 during the reset cycle.
  - Reset mid-transfer drops the held beat and restores the credits.
- Eligibility: elig = credit_avail. Credits returned in the current cycle are not eligible until the next cycle.
- Selection:
  - Take the lowest eligible index strictly above out_bin (msb side).
  - Otherwise take the lowest eligible index at or below out_bin, wrapping around (lsb side).
  - out_bin itself is re-selected only if no other consumer is eligible.
- Ready rule: in_ready = (~out_valid | out_ready) & |elig. It is combinational from the register state, out_ready and the credit counters; it never depends on in_valid.
- Load (in_valid&in_ready), one-cycle latency:
  - out_valid<=1, out_data<=in_data, out_bin<=sel.
  - credit[sel] is decremented.
- Unload only (out_valid&out_ready, no load): out_valid<=0. out_bin is retained, so the pointer persists.
- Hold: while out_valid&~out_ready, out_data, out_bin and out_valid stay stable.
- Back-to-back: unload and load in the same cycle sustain 1 beat/clk when credits allow.
- Credit counter per consumer:
  - next = cur - dec + cred_ret[i].
  - Simultaneous decrement and return nets to no change.
  - A return at max credit saturates at max (overflow, see optional feature).
  - A decrement at 0 cannot occur by construction.
- No eligible consumer: in_ready=0. The input stalls and the held output beat is unaffected.

Optional Feature:
- Macro: LDL_RR_DISPATCH_OVF_CHK_EN.
- Defined:
  - Adds output port ovf_err (1 bit), sticky.
  - ovf_err is set the cycle after any cred_ret[i] arrives while credit i is at max with no same-cycle decrement.
  - ovf_err is cleared only by rst.
- Undefined: port absent; saturation is silent.

Decomposition:
- Package ldl_rr_dispatch_pkg holds:
  - localparam CREDIT_MAX function of CREDIT_WIDTH;
  - a typedef for the credit counter;
  - the rotate-priority select function (pointer, elig) -> (sel, found).
- Sub-module ldl_rr_credit_ctr_v1: one saturating up/down credit counter with a nonzero flag and an overflow pulse. It is instantiated REQ_WIDTH times via generate.

Test Plan:
- Basic rotation (BIN_WIDTH=2, CREDIT_INIT=3, out_ready=1, no returns): 6 beats D0..D5 -> out_bin 0,1,2,3,0,1; out_hot 0001,0010,0100,1000,0001,0010; out_data matches; 1 beat/clk.
- Credit exhaustion (CREDIT_INIT=1): 4 beats accepted to bins 0..3, then in_ready=0. Pulse cred_ret=0100 -> next beat goes to bin 2, next cycle.
- Skip and sole-eligible (CREDIT_INIT=1): after beat 1 to bin 0, return only credit 0 -> next beat goes to bin 0 again (sole eligible, re-selected). Credit 1 returned later -> goes to bin 1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_valid/out_data/out_bin stable, in_ready=0, credits decremented once only. Release -> transfer, then the next beat loads the same cycle.
- Simultaneous load and return on the selected consumer at credit 1 -> counter stays 1 and credit_avail is unchanged. Reset asserted while out_valid=1 -> next cycle out_valid=0, out_bin=3, all credits=CREDIT_INIT.
- With LDL_RR_DISPATCH_OVF_CHK_EN: cred_ret[0] at credit 3 (max) -> ovf_err=1 the next cycle, held until rst; counter stays 3.

Source files
------------

// File: rtl/ldl_rr_dispatch_pkg.sv
// Shared types, credit limits and the rotate-priority selector for the round-robin dispatcher.
// Optional overflow checking in the top is enabled with LDL_RR_DISPATCH_OVF_CHK_EN.
package ldl_rr_dispatch_pkg;

    localparam int DEF_CREDIT_WIDTH = 2;
    localparam int MAX_BIN          = 6;
    localparam int MAX_REQ          = 1 << MAX_BIN;

    function automatic int credit_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int CREDIT_MAX = credit_max(DEF_CREDIT_WIDTH);

    typedef logic [DEF_CREDIT_WIDTH-1:0] credit_t;

    // Returns {found, sel}: lowest eligible index above ptr, else lowest eligible overall.
    function automatic logic [MAX_BIN:0] rr_select(
        input logic [MAX_BIN-1:0] ptr,
        input logic [MAX_REQ-1:0] elig
    );
        logic [MAX_REQ-1:0] hi;
        logic [MAX_BIN-1:0] sel_hi;
        logic [MAX_BIN-1:0] sel_lo;
        logic               found_hi;
        logic               found_lo;
        hi       = '0;
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            hi[i] = elig[i] && (i > int'(ptr));
        end
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (hi[i]) begin
                sel_hi   = MAX_BIN'(i);
                found_hi = 1'b1;
            end
            if (elig[i]) begin
                sel_lo   = MAX_BIN'(i);
                found_lo = 1'b1;
            end
        end
        return found_hi ? {1'b1, sel_hi} : {found_lo, sel_lo};
    endfunction

endpackage

// File: rtl/ldl_rr_credit_ctr_v1.sv
// One saturating up/down credit counter with a nonzero flag and an overflow pulse.
module ldl_rr_credit_ctr_v1
    import ldl_rr_dispatch_pkg::*;
#(
    parameter int CREDIT_WIDTH = 2,
    parameter int CREDIT_INIT  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic dec_i,
    input  logic inc_i,
    output logic nz_o,
    output logic ovf_o
);

    localparam logic [CREDIT_WIDTH-1:0] MAX  = CREDIT_WIDTH'(credit_max(CREDIT_WIDTH));
    localparam logic [CREDIT_WIDTH-1:0] INIT = CREDIT_WIDTH'(CREDIT_INIT);

    logic [CREDIT_WIDTH-1:0] cnt_q;
    logic [CREDIT_WIDTH-1:0] cnt_d;

    // A return and a decrement in the same cycle cancel; a lone return at max is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (dec_i && !inc_i) begin
            cnt_d = cnt_q - 1'b1;
        end else if (inc_i && !dec_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o  = (cnt_q != '0);
    assign ovf_o = inc_i && !dec_i && (cnt_q == MAX);

endmodule

// File: rtl/ldl_rr_dispatch_v1.sv
// Credit-gated round-robin dispatcher: one input stream to REQ_WIDTH consumers via a registered beat.
// Define LDL_RR_DISPATCH_OVF_CHK_EN to add the sticky ovf_err credit-overflow output.
module ldl_rr_dispatch_v1
    import ldl_rr_dispatch_pkg::*;
#(
    parameter int BIN_WIDTH    = 3,
    parameter int REQ_WIDTH    = 1 << BIN_WIDTH,
    parameter int DATA_WIDTH   = 32,
    parameter int CREDIT_WIDTH = 2,
    parameter int CREDIT_INIT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [REQ_WIDTH-1:0]  cred_ret,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [BIN_WIDTH-1:0]  out_bin,
    output logic [REQ_WIDTH-1:0]  out_hot,
    output logic [REQ_WIDTH-1:0]  credit_avail
`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
    ,
    output logic                  ovf_err
`endif
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [BIN_WIDTH-1:0]  out_bin_q,   out_bin_d;

    logic [REQ_WIDTH-1:0]  elig;
    logic [REQ_WIDTH-1:0]  dec;
    logic [REQ_WIDTH-1:0]  ovf_pulse;
    logic [MAX_REQ-1:0]    elig_ext;
    logic [MAX_BIN-1:0]    ptr_ext;
    logic [MAX_BIN:0]      pick;
    logic [BIN_WIDTH-1:0]  sel;
    logic                  found;
    logic                  load;

    // Eligibility comes from registered counts, so a credit returned this cycle waits one clock.
    assign elig = credit_avail;

    always_comb begin
        elig_ext                = '0;
        elig_ext[REQ_WIDTH-1:0] = elig;
        ptr_ext                 = '0;
        ptr_ext[BIN_WIDTH-1:0]  = out_bin_q;
    end

    assign pick     = rr_select(ptr_ext, elig_ext);
    assign found    = pick[MAX_BIN];
    assign sel      = pick[BIN_WIDTH-1:0];
    assign in_ready = !rst && (!out_valid_q || out_ready) && found;
    assign load     = in_valid && in_ready;

    always_comb begin
        dec = '0;
        if (load) begin
            dec[sel] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_bin_d   = out_bin_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_bin_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // The pointer starts at the top index so the first dispatch lands on consumer 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bin_q   <= BIN_WIDTH'(REQ_WIDTH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bin_q   <= out_bin_d;
        end
    end

    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_ctr
        ldl_rr_credit_ctr_v1 #(
            .CREDIT_WIDTH (CREDIT_WIDTH),
            .CREDIT_INIT  (CREDIT_INIT)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .dec_i (dec[g]),
            .inc_i (cred_ret[g]),
            .nz_o  (credit_avail[g]),
            .ovf_o (ovf_pulse[g])
        );
    end

`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (|ovf_pulse) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = |ovf_pulse;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bin   = out_bin_q;
    assign out_hot   = out_valid_q ? (REQ_WIDTH'(1) << out_bin_q) : '0;

endmodule

// File: tb/tb_ldl_rr_dispatch_v1.sv
// Self-checking bench for ldl_rr_dispatch_v1 (4 consumers): vector table, directed corners, random vs model.
module tb_ldl_rr_dispatch_v1;

    localparam int BW   = 2;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int CINI = 3;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [N-1:0]  cred_ret;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [BW-1:0] out_bin;
    logic [N-1:0]  out_hot;
    logic [N-1:0]  credit_avail;
`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
    logic          ovf_err;
`endif

    ldl_rr_dispatch_v1 #(
        .BIN_WIDTH    (BW),
        .REQ_WIDTH    (N),
        .DATA_WIDTH   (DW),
        .CREDIT_WIDTH (CW),
        .CREDIT_INIT  (CINI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cred_ret     (cred_ret),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bin      (out_bin),
        .out_hot      (out_hot),
        .credit_avail (credit_avail)
`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
        ,
        .ovf_err      (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-consumer credit counts, pointer and output register.
    int            m_cred[N];
    int            m_ptr;
    bit            m_ov;
    logic [DW-1:0] m_od;
    bit            m_ovf;
    logic          s_in_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_any();
        for (int i = 0; i < N; i++) if (m_cred[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Walk consumers starting just past the pointer, wrapping; first with credit wins.
    function automatic int m_sel();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (m_cred[idx] > 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_ready(input bit ordy);
        return (!m_ov || ordy) && m_any();
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_cred[i] = CINI;
        m_ptr = N - 1;
        m_ov  = 1'b0;
        m_od  = '0;
        m_ovf = 1'b0;
    endtask

    task automatic m_clock(input bit iv, input logic [DW-1:0] d, input bit ordy, input logic [N-1:0] cr);
        bit ld;
        int s;
        ld = iv && m_ready(ordy);
        s  = m_sel();
        for (int i = 0; i < N; i++) begin
            int dc;
            dc = (ld && s == i) ? 1 : 0;
            if (cr[i] && m_cred[i] == CMAX && dc == 0) m_ovf = 1'b1;
            m_cred[i] = m_cred[i] - dc + int'(cr[i]);
            if (m_cred[i] > CMAX) m_cred[i] = CMAX;
        end
        if (ld) begin
            m_ov  = 1'b1;
            m_od  = d;
            m_ptr = s;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] av;
        logic [N-1:0] hot;
        for (int i = 0; i < N; i++) av[i] = (m_cred[i] > 0);
        hot = m_ov ? (N'(1) << m_ptr) : '0;
        chk("m_out_valid", out_valid, m_ov);
        chk("m_out_data", out_data, m_od);
        chk("m_out_bin", out_bin, m_ptr);
        chk("m_out_hot", out_hot, hot);
        chk("m_credit_avail", credit_avail, av);
`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
        chk("m_ovf_err", ovf_err, m_ovf);
`endif
    endtask

    // One clock: drive at negedge, sample in_ready before the edge, outputs 1ns after it.
    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input logic [N-1:0] cr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        cred_ret  = cr;
        #1;
        s_in_ready = in_ready;
        if (rst) chk("in_ready_rst", in_ready, 1'b0);
        else     chk("m_in_ready", in_ready, m_ready(ordy));
        @(posedge clk);
        if (rst) m_reset();
        else     m_clock(iv, d, ordy, cr);
        #1;
        check_model();
    endtask

    typedef struct {
        bit           iv;
        logic [31:0]  d;
        bit           ordy;
        logic [N-1:0] cr;
        bit           e_rdy;
        bit           e_ov;
        logic [BW-1:0] e_bin;
        logic [N-1:0] e_hot;
        logic [31:0]  e_data;
        logic [N-1:0] e_avail;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 32'hD000_0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hD000_0000, 4'b1111};
        tbl[1] = '{1'b1, 32'hD000_0001, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 32'hD000_0001, 4'b1111};
        tbl[2] = '{1'b1, 32'hD000_0002, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 32'hD000_0002, 4'b1111};
        tbl[3] = '{1'b1, 32'hD000_0003, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 32'hD000_0003, 4'b1111};
        tbl[4] = '{1'b1, 32'hD000_0004, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hD000_0004, 4'b1111};
        tbl[5] = '{1'b1, 32'hD000_0005, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 32'hD000_0005, 4'b1111};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cred_ret = '0;
        m_reset();

        // Reset state, with a beat offered during reset.
        step(1'b1, 32'hAAAA_AAAA, 1'b1, 4'b0000);
        step(1'b1, 32'hAAAA_AAAA, 1'b1, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_bin", out_bin, 2'd3);
        chk("rst_out_hot", out_hot, 4'b0000);
        chk("rst_avail", credit_avail, 4'b1111);
        rst = 1'b0;

        // Basic rotation at 1 beat/clk.
        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].cr);
            chk("rot_in_ready", s_in_ready, tbl[i].e_rdy);
            chk("rot_out_valid", out_valid, tbl[i].e_ov);
            chk("rot_out_bin", out_bin, tbl[i].e_bin);
            chk("rot_out_hot", out_hot, tbl[i].e_hot);
            chk("rot_out_data", out_data, tbl[i].e_data);
            chk("rot_avail", credit_avail, tbl[i].e_avail);
        end

        // Reset, then spend 2 credits each so every consumer holds exactly 1.
        rst = 1'b1;
        step(1'b0, '0, 1'b1, '0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + i, 1'b1, '0);

        // Credit exhaustion.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h2000 + i, 1'b1, '0);
            chk("exh_bin", out_bin, i);
        end
        chk("exh_avail", credit_avail, 4'b0000);
        step(1'b1, 32'h2FFF, 1'b1, 4'b0100);
        chk("exh_stall_ready", s_in_ready, 1'b0);
        chk("exh_drained", out_valid, 1'b0);
        chk("exh_ret_avail", credit_avail, 4'b0100);
        step(1'b1, 32'h2004, 1'b1, '0);
        chk("exh_ret_ready", s_in_ready, 1'b1);
        chk("exh_ret_bin", out_bin, 2'd2);
        chk("exh_ret_hot", out_hot, 4'b0100);

        // Skip and sole-eligible re-selection.
        step(1'b0, '0, 1'b1, 4'b0001);
        step(1'b1, 32'h3001, 1'b1, '0);
        chk("skip_bin0", out_bin, 2'd0);
        step(1'b0, '0, 1'b1, 4'b0001);
        step(1'b1, 32'h3002, 1'b1, '0);
        chk("sole_bin0", out_bin, 2'd0);
        chk("sole_data", out_data, 32'h3002);
        step(1'b0, '0, 1'b1, 4'b0010);
        step(1'b1, 32'h3003, 1'b1, '0);
        chk("skip_bin1", out_bin, 2'd1);

        // Backpressure: hold for 5 cycles, then release with back-to-back load.
        step(1'b0, '0, 1'b1, 4'b1111);
        step(1'b1, 32'h4000, 1'b0, '0);
        chk("bp_first_ready", s_in_ready, 1'b1);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, 32'h4000 + i, 1'b0, '0);
            chk("bp_ready", s_in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, 32'h4000);
            chk("bp_bin", out_bin, 2'd2);
            chk("bp_avail", credit_avail, 4'b1011);
        end
        step(1'b1, 32'h4009, 1'b1, '0);
        chk("bp_rel_ready", s_in_ready, 1'b1);
        chk("bp_rel_bin", out_bin, 2'd3);
        chk("bp_rel_data", out_data, 32'h4009);
        chk("bp_rel_avail", credit_avail, 4'b0011);

        // Load and return on the selected consumer at credit 1 nets to no change.
        step(1'b1, 32'h5000, 1'b1, 4'b0001);
        chk("net_bin", out_bin, 2'd0);
        chk("net_avail", credit_avail, 4'b0011);
        step(1'b1, 32'h5001, 1'b1, '0);
        chk("net_next_bin", out_bin, 2'd1);
        step(1'b1, 32'h5002, 1'b1, '0);
        chk("net_still1_bin", out_bin, 2'd0);
        chk("net_empty_avail", credit_avail, 4'b0000);

        // Reset while a beat is held.
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        step(1'b1, 32'h6000, 1'b0, '0);
        chk("mid_rst_ready", s_in_ready, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_bin", out_bin, 2'd3);
        chk("mid_rst_avail", credit_avail, 4'b1111);
        rst = 1'b0;

`ifdef LDL_RR_DISPATCH_OVF_CHK_EN
        step(1'b0, '0, 1'b1, 4'b0001);
        chk("ovf_set", ovf_err, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, '0);
        chk("ovf_sticky", ovf_err, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h7000 + i, 1'b1, '0);
        chk("ovf_sat_drain", credit_avail, 4'b0000);
        rst = 1'b1;
        step(1'b0, '0, 1'b1, '0);
        rst = 1'b0;
        chk("ovf_cleared", ovf_err, 1'b0);
`endif

        // Randomized traffic, returns and occasional reset against the model.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] cr;
            for (int b = 0; b < N; b++) cr[b] = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, cr);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
